// File: rtl/seg_adder_scan.sv
// rtl/seg_adder_scan.sv - registered adder with hex/BCD conversion driving a scanned seven-segment display
module seg_adder_scan #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              start,
  input  logic              dec_mode,
  output logic              busy,
  output logic              done,
  output logic [WIDTH:0]    sum,
  output logic              overflow,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int SW = WIDTH + 1;
  localparam int DW = 4 * DIGITS;
  localparam int XW = (SW > DW) ? SW : DW;
  localparam int CW = $clog2(SW + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v;
  endfunction

  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'h0: enc7 = 7'h40;
      4'h1: enc7 = 7'h79;
      4'h2: enc7 = 7'h24;
      4'h3: enc7 = 7'h30;
      4'h4: enc7 = 7'h19;
      4'h5: enc7 = 7'h12;
      4'h6: enc7 = 7'h02;
      4'h7: enc7 = 7'h78;
      4'h8: enc7 = 7'h00;
      4'h9: enc7 = 7'h10;
      4'hA: enc7 = 7'h08;
      4'hB: enc7 = 7'h03;
      4'hC: enc7 = 7'h46;
      4'hD: enc7 = 7'h21;
      4'hE: enc7 = 7'h06;
      default: enc7 = 7'h0E;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_CONV} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_dec;
  logic              r_busy;
  logic              r_done;
  logic              r_ovf;
  logic [SW-1:0]     r_sum;
  logic [SW-1:0]     r_sh;
  logic [DW-1:0]     r_bcd;
  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_digits;
  logic [PW-1:0]     r_pre;
  logic [IW-1:0]     r_idx;

  logic              w_accept;
  logic              w_last;
  logic [SW-1:0]     w_add;
  logic [DW-1:0]     w_bcd_adj;
  logic [DW-1:0]     w_bcd_next;
  logic [XW-1:0]     w_sum_ext;
  logic [DW-1:0]     w_hex_dig;
  logic              w_hex_ovf;
  logic              w_dec_ovf;
  logic [3:0]        w_dig [DIGITS];
  logic [DIGITS-1:0] w_keep;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_last    = (r_state == S_CONV) && (!r_dec || (r_cnt == CW'(SW - 1)));
  assign w_add     = {1'b0, a} + {1'b0, b};
  assign w_sum_ext = XW'(r_sum);
  assign w_hex_dig = w_sum_ext[DW-1:0];
  assign w_hex_ovf = |(w_sum_ext >> DW);
  assign w_dec_ovf = (64'(r_sum) > DEC_MAX);

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state: accept a request in IDLE, leave CONV on the final conversion edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start)  w_state_nxt = S_CONV;
      S_CONV: if (w_last) w_state_nxt = S_IDLE;
      default:            w_state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step: +3 on nibbles >= 5, then shift in the next sum bit MSB first.
  // BCD digits above DIGITS are dropped; they never influence the lower digits.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_next = {w_bcd_adj[DW-2:0], r_sh[SW-1]};
  end

  // Datapath: capture sum, iterate conversion, load digits only on the last edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dec    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_sum    <= '0;
      r_sh     <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_digits <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_sum  <= w_add;
        r_sh   <= w_add;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_dec  <= dec_mode;
        r_busy <= 1'b1;
      end else if (r_state == S_CONV) begin
        if (r_dec) begin
          r_bcd <= w_bcd_next;
          r_sh  <= r_sh << 1;
          r_cnt <= r_cnt + CW'(1);
        end
        if (w_last) begin
          r_digits <= r_dec ? w_bcd_next : w_hex_dig;
          r_ovf    <= r_dec ? w_dec_ovf : w_hex_ovf;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign w_dig[g] = r_digits[4*g +: 4];
  end

  // Leading-zero blanking: keep a digit if it or any digit above it is nonzero; digit 0 always kept
  always_comb begin
    logic v_acc;
    v_acc  = 1'b0;
    w_keep = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      v_acc     = v_acc | (w_dig[i] != 4'd0) | (i == 0);
      w_keep[i] = v_acc;
    end
  end

  // Free-running scan: prescaler holds each digit SCAN_DIV cycles, then advances the index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == PW'(SCAN_DIV - 1)) begin
      r_pre <= '0;
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign an       = ~(DIGITS'(1) << r_idx);
  assign seg      = w_keep[r_idx] ? enc7(w_dig[r_idx]) : 7'h7F;
  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_seg_adder_scan.sv
// tb/tb_seg_adder_scan.sv - table-driven bench for seg_adder_scan (3-digit and 2-digit instances)
module tb_seg_adder_scan;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       start;
  logic       dec_mode;

  logic       busy3, done3, ovf3;
  logic [8:0] sum3;
  logic [6:0] seg3;
  logic [2:0] an3;

  logic       busy2, done2, ovf2;
  logic [8:0] sum2;
  logic [6:0] seg2;
  logic [1:0] an2;

  int tests = 0;
  int fails = 0;

  seg_adder_scan #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start), .dec_mode(dec_mode),
    .busy(busy3), .done(done3), .sum(sum3), .overflow(ovf3), .seg(seg3), .an(an3)
  );

  seg_adder_scan #(.WIDTH(8), .DIGITS(2), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .start(start), .dec_mode(dec_mode),
    .busy(busy2), .done(done2), .sum(sum2), .overflow(ovf2), .seg(seg2), .an(an2)
  );

  typedef struct {
    logic [7:0]      a;
    logic [7:0]      b;
    logic            dec;
    logic [8:0]      sum;
    logic            ovf3;
    logic [2:0][6:0] s3;
    logic            ovf2;
    logic [1:0][6:0] s2;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic read3(input int k, input logic [6:0] exp, input string nm);
    logic [2:0] want;
    bit         got;
    want = ~(3'b001 << k);
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (an3 == want) begin
        got = 1'b1;
        chk(nm, seg3, exp);
      end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic read2(input int k, input logic [6:0] exp, input string nm);
    logic [1:0] want;
    bit         got;
    want = ~(2'b01 << k);
    got  = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (an2 == want) begin
        got = 1'b1;
        chk(nm, seg2, exp);
      end
    end
    if (!got) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat;
    int bcnt;
    int exp_lat;
    bit got;
    exp_lat = v.dec ? 9 : 1;
    @(negedge clk);
    a = v.a; b = v.b; dec_mode = v.dec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d_sum", n), sum3, v.sum);
    chk($sformatf("v%0d_sum2", n), sum2, v.sum);
    chk($sformatf("v%0d_busy_e0", n), busy3, 1);
    lat = 0; bcnt = 1; got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (done3) begin
        got = 1'b1;
        lat = k;
      end else if (busy3) begin
        bcnt++;
      end
    end
    chk($sformatf("v%0d_latency", n), lat, exp_lat);
    chk($sformatf("v%0d_busy_cycles", n), bcnt, exp_lat);
    chk($sformatf("v%0d_busy_at_done", n), busy3, 0);
    chk($sformatf("v%0d_done2", n), done2, 1);
    chk($sformatf("v%0d_ovf3", n), ovf3, v.ovf3);
    chk($sformatf("v%0d_ovf2", n), ovf2, v.ovf2);
    @(negedge clk);
    chk($sformatf("v%0d_done_width", n), done3, 0);
    for (int k = 0; k < 3; k++) read3(k, v.s3[k], $sformatf("v%0d_seg3_d%0d", n, k));
    for (int k = 0; k < 2; k++) read2(k, v.s2[k], $sformatf("v%0d_seg2_d%0d", n, k));
    chk($sformatf("v%0d_ovf3_held", n), ovf3, v.ovf3);
  endtask

  initial begin
    int         dcnt;
    logic [2:0] exp_an3;
    logic [1:0] exp_an2;

    //           a      b      dec   sum     ovf3  {d2,d1,d0}                 ovf2  {d1,d0}
    vt[0]  = '{8'd2,   8'd4,   1'b0, 9'd6,   1'b0, {7'h7F, 7'h7F, 7'h02}, 1'b0, {7'h7F, 7'h02}};
    vt[1]  = '{8'd255, 8'd255, 1'b1, 9'h1FE, 1'b0, {7'h12, 7'h79, 7'h40}, 1'b1, {7'h79, 7'h40}};
    vt[2]  = '{8'd60,  8'd50,  1'b1, 9'd110, 1'b0, {7'h79, 7'h79, 7'h40}, 1'b1, {7'h79, 7'h40}};
    vt[3]  = '{8'd255, 8'd255, 1'b0, 9'h1FE, 1'b0, {7'h79, 7'h0E, 7'h06}, 1'b1, {7'h0E, 7'h06}};
    vt[4]  = '{8'd0,   8'd0,   1'b1, 9'd0,   1'b0, {7'h7F, 7'h7F, 7'h40}, 1'b0, {7'h7F, 7'h40}};
    vt[5]  = '{8'd99,  8'd0,   1'b1, 9'd99,  1'b0, {7'h7F, 7'h10, 7'h10}, 1'b0, {7'h10, 7'h10}};
    vt[6]  = '{8'd100, 8'd0,   1'b1, 9'd100, 1'b0, {7'h79, 7'h40, 7'h40}, 1'b1, {7'h7F, 7'h40}};
    vt[7]  = '{8'h80,  8'h7F,  1'b0, 9'h0FF, 1'b0, {7'h7F, 7'h0E, 7'h0E}, 1'b0, {7'h0E, 7'h0E}};
    vt[8]  = '{8'h80,  8'h80,  1'b0, 9'h100, 1'b0, {7'h79, 7'h40, 7'h40}, 1'b1, {7'h7F, 7'h40}};
    vt[9]  = '{8'd123, 8'd45,  1'b1, 9'd168, 1'b0, {7'h79, 7'h02, 7'h00}, 1'b1, {7'h02, 7'h00}};
    vt[10] = '{8'hAB,  8'h01,  1'b0, 9'h0AC, 1'b0, {7'h7F, 7'h08, 7'h46}, 1'b0, {7'h08, 7'h46}};
    vt[11] = '{8'd7,   8'd7,   1'b1, 9'd14,  1'b0, {7'h7F, 7'h79, 7'h19}, 1'b0, {7'h79, 7'h19}};

    rst_n = 1'b0; a = '0; b = '0; start = 1'b0; dec_mode = 1'b0;

    // reset state and scan sequence
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_sum", sum3, 0);
    chk("rst_ovf", ovf3, 0);
    chk("rst_seg", seg3, 7'h40);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      exp_an3 = ~(3'b001 << ((i / 4) % 3));
      exp_an2 = ~(2'b01 << ((i / 4) % 2));
      chk($sformatf("scan_an3_%0d", i), an3, exp_an3);
      chk($sformatf("scan_an2_%0d", i), an2, exp_an2);
    end

    // table-driven conversions
    for (int i = 0; i < 12; i++) run_vec(vt[i], i);

    // start while busy is ignored
    @(negedge clk);
    a = 8'd7; b = 8'd7; dec_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    for (int k = 4; k <= 20 && dcnt == 0; k++) begin
      @(negedge clk);
      if (done3) begin
        dcnt = k;
      end
    end
    chk("busy_ign_latency", dcnt, 9);
    chk("busy_ign_sum", sum3, 14);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done3) dcnt++;
    end
    chk("busy_ign_no_queue", dcnt, 0);
    read3(0, 7'h19, "busy_ign_d0");
    read3(1, 7'h79, "busy_ign_d1");

    // reset in the middle of a decimal conversion
    @(negedge clk);
    a = 8'd50; b = 8'd50; dec_mode = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy3, 0);
    chk("midrst_done", done3, 0);
    chk("midrst_sum", sum3, 0);
    chk("midrst_an", an3, 3'b110);
    chk("midrst_seg", seg3, 7'h40);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done3) dcnt++;
    end
    chk("midrst_no_done", dcnt, 0);
    read3(1, 7'h7F, "midrst_d1");

    // back-to-back: restart in the done cycle
    @(negedge clk);
    a = 8'd7; b = 8'd1; dec_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_done1", done3, 1);
    chk("b2b_sum1", sum3, 8);
    chk("b2b_seg1", seg3, (an3 == 3'b110) ? 7'h00 : 7'h7F);
    a = 8'd0; b = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_gap_done", done3, 0);
    chk("b2b_gap_busy", busy3, 1);
    chk("b2b_sum2", sum3, 0);
    @(negedge clk);
    chk("b2b_done2", done3, 1);
    read3(0, 7'h40, "b2b_d0");
    read3(1, 7'h7F, "b2b_d1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
